// File: rtl/multi_transfer_sequencer_pkg.sv
// Shared constants for the LM/SM block-transfer sequencer.
package multi_transfer_sequencer_pkg;

    localparam int unsigned WIDTH_DEF    = 16;
    localparam int unsigned NUM_REGS_DEF = 8;

    // Opcode occupies the top OPC_BITS of the instruction; the register mask sits in the
    // low NUM_REGS bits; rA is at [RA_MSB:RA_LSB] (carried through in the shadow bits).
    localparam int unsigned OPC_BITS = 4;
    localparam int unsigned RA_MSB   = 11;
    localparam int unsigned RA_LSB   = 9;

    localparam logic [OPC_BITS-1:0] OPC_LM_DEF = 4'b0110;
    localparam logic [OPC_BITS-1:0] OPC_SM_DEF = 4'b0111;

    // True when the opcode names a block load or block store.
    function automatic logic is_block_xfer(input logic [OPC_BITS-1:0] opc,
                                           input logic [OPC_BITS-1:0] lm,
                                           input logic [OPC_BITS-1:0] sm);
        return (opc == lm) || (opc == sm);
    endfunction

endpackage

// File: rtl/multi_transfer_sequencer_if.sv
// Decode-stage handshake between IF/ID, the sequencer and ID/RR.
interface multi_transfer_sequencer_if
    import multi_transfer_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned RIDX  = $clog2(NUM_REGS_DEF)
);
    logic             in_valid;
    logic [WIDTH-1:0] in_ir;
    logic             in_ready;
    logic             stall_in;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] out_ir;
    logic             out_multi;
    logic             out_first;
    logic             out_last;
    logic [RIDX-1:0]  out_reg;
    logic [WIDTH-1:0] out_offset;
    logic             busy;

    // Pipeline side: supplies instructions and control, observes micro-ops.
    modport master (
        output in_valid, in_ir, stall_in, flush,
        input  in_ready, out_valid, out_ir, out_multi, out_first, out_last,
               out_reg, out_offset, busy
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_ir, stall_in, flush,
        output in_ready, out_valid, out_ir, out_multi, out_first, out_last,
               out_reg, out_offset, busy
    );
endinterface

// File: rtl/multi_transfer_sequencer_lowest_set_bit_enc.sv
// Finds the lowest set bit of a register mask; purely combinational.
module multi_transfer_sequencer_lowest_set_bit_enc
    import multi_transfer_sequencer_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned RIDX     = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0] mask,
    output logic [RIDX-1:0]     idx,
    output logic [NUM_REGS-1:0] onehot,
    output logic [NUM_REGS-1:0] rest,
    output logic                rest_zero
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = int'(NUM_REGS) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = RIDX'(i);
            end
        end
    end

    // Two's-complement trick isolates the lowest set bit.
    assign onehot    = mask & (~mask + NUM_REGS'(1));
    assign rest      = mask & ~onehot;
    assign rest_zero = (rest == '0);

endmodule

// File: rtl/multi_transfer_sequencer.sv
// Expands LM/SM instructions into one single-register micro-op per set mask bit,
// stalling fetch through in_ready while the expansion is in progress.
module multi_transfer_sequencer
    import multi_transfer_sequencer_pkg::*;
#(
    parameter int unsigned          WIDTH     = WIDTH_DEF,
    parameter int unsigned          NUM_REGS  = NUM_REGS_DEF, // must be <= WIDTH-7
    parameter int unsigned          RIDX      = $clog2(NUM_REGS),
    parameter logic [OPC_BITS-1:0]  OPC_LM    = OPC_LM_DEF,
    parameter logic [OPC_BITS-1:0]  OPC_SM    = OPC_SM_DEF,
    parameter int unsigned          ADDR_STEP = 1
) (
    input logic                       clk,
    input logic                       reset,
    multi_transfer_sequencer_if.slave bus
);

    localparam int unsigned SHW = WIDTH - NUM_REGS;

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [SHW-1:0]      shadow_q, shadow_d;
    logic                valid_q, valid_d;
    logic [WIDTH-1:0]    ir_q, ir_d;
    logic                multi_q, multi_d;
    logic                first_q, first_d;
    logic                last_q, last_d;
    logic [RIDX-1:0]     reg_q, reg_d;
    logic [WIDTH-1:0]    offset_q, offset_d;

    logic                expanding;
    logic                in_ready;
    logic                accept;
    logic                block_op;
    logic [NUM_REGS-1:0] in_mask;
    logic [NUM_REGS-1:0] enc_mask;
    logic [RIDX-1:0]     enc_idx;
    logic [NUM_REGS-1:0] enc_onehot;
    logic [NUM_REGS-1:0] enc_rest;
    logic                enc_rest_zero;

    assign expanding = (pending_q != '0);
    assign in_ready  = !expanding && !bus.stall_in && !bus.flush;
    assign accept    = bus.in_valid && in_ready;
    assign in_mask   = bus.in_ir[NUM_REGS-1:0];
    assign block_op  = is_block_xfer(bus.in_ir[WIDTH-1 -: OPC_BITS], OPC_LM, OPC_SM);

    // One encoder serves both the fresh instruction and the pending mask.
    assign enc_mask = expanding ? pending_q : in_mask;

    multi_transfer_sequencer_lowest_set_bit_enc #(
        .NUM_REGS (NUM_REGS),
        .RIDX     (RIDX)
    ) u_enc (
        .mask      (enc_mask),
        .idx       (enc_idx),
        .onehot    (enc_onehot),
        .rest      (enc_rest),
        .rest_zero (enc_rest_zero)
    );

    // Next-state: flush beats stall, stall beats everything else.
    always_comb begin
        pending_d = pending_q;
        shadow_d  = shadow_q;
        valid_d   = valid_q;
        ir_d      = ir_q;
        multi_d   = multi_q;
        first_d   = first_q;
        last_d    = last_q;
        reg_d     = reg_q;
        offset_d  = offset_q;

        if (bus.flush) begin
            pending_d = '0;
            valid_d   = 1'b0;
            multi_d   = 1'b0;
            first_d   = 1'b0;
            last_d    = 1'b0;
        end else if (!bus.stall_in) begin
            if (expanding) begin
                valid_d   = 1'b1;
                ir_d      = {shadow_q, enc_onehot};
                multi_d   = 1'b1;
                first_d   = 1'b0;
                last_d    = enc_rest_zero;
                reg_d     = enc_idx;
                offset_d  = offset_q + WIDTH'(ADDR_STEP);
                pending_d = enc_rest;
            end else if (accept && block_op && (in_mask != '0)) begin
                valid_d   = 1'b1;
                ir_d      = {bus.in_ir[WIDTH-1:NUM_REGS], enc_onehot};
                multi_d   = 1'b1;
                first_d   = 1'b1;
                last_d    = enc_rest_zero;
                reg_d     = enc_idx;
                offset_d  = '0;
                pending_d = enc_rest;
                shadow_d  = bus.in_ir[WIDTH-1:NUM_REGS];
            end else if (accept && !block_op) begin
                valid_d   = 1'b1;
                ir_d      = bus.in_ir;
                multi_d   = 1'b0;
                first_d   = 1'b0;
                last_d    = 1'b0;
                reg_d     = '0;
                offset_d  = '0;
            end else begin
                // Bubble, including an LM/SM with an empty mask.
                valid_d   = 1'b0;
                multi_d   = 1'b0;
                first_d   = 1'b0;
                last_d    = 1'b0;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            shadow_q  <= '0;
            valid_q   <= 1'b0;
            ir_q      <= '0;
            multi_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            reg_q     <= '0;
            offset_q  <= '0;
        end else begin
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            valid_q   <= valid_d;
            ir_q      <= ir_d;
            multi_q   <= multi_d;
            first_q   <= first_d;
            last_q    <= last_d;
            reg_q     <= reg_d;
            offset_q  <= offset_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = valid_q;
    assign bus.out_ir     = ir_q;
    assign bus.out_multi  = multi_q;
    assign bus.out_first  = first_q;
    assign bus.out_last   = last_q;
    assign bus.out_reg    = reg_q;
    assign bus.out_offset = offset_q;
    assign bus.busy       = expanding;

endmodule

// File: tb/tb_multi_transfer_sequencer.sv
// Randomised and directed bench for multi_transfer_sequencer with a queue-based model.
module tb_multi_transfer_sequencer;

    localparam logic [15:0] ADD = 16'h0A53;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multi_transfer_sequencer_if #(.WIDTH(16), .RIDX(3)) bus ();
    multi_transfer_sequencer_if #(.WIDTH(24), .RIDX(4)) b2 ();

    multi_transfer_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    multi_transfer_sequencer #(
        .WIDTH     (24),
        .NUM_REGS  (12),
        .RIDX      (4),
        .ADDR_STEP (2)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );

    typedef struct {
        logic [15:0] ir;
        logic        multi;
        logic        first;
        logic        last;
        logic [2:0]  rg;
        logic [15:0] off;
    } uop_t;

    uop_t q[$];
    uop_t cur;
    bit   cur_v = 1'b0;
    bit   chk_en = 1'b0;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted LM/SM is expanded up-front into a list of micro-ops,
    // which are then issued one per unstalled cycle.
    task automatic model_step(input logic v, input logic [15:0] ir, input logic st,
                              input logic fl);
        uop_t u;
        int   n;
        if (fl) begin
            q.delete();
            cur_v = 1'b0;
        end else if (st) begin
            // hold
        end else if (q.size() > 0) begin
            cur   = q.pop_front();
            cur_v = 1'b1;
        end else if (v) begin
            if (ir[15:12] == 4'b0110 || ir[15:12] == 4'b0111) begin
                if (ir[7:0] == 8'h00) begin
                    cur_v = 1'b0;
                end else begin
                    n = 0;
                    for (int b = 0; b < 8; b++) begin
                        if (ir[b]) begin
                            u.ir    = {ir[15:8], 8'(1 << b)};
                            u.multi = 1'b1;
                            u.first = (n == 0);
                            u.last  = 1'b0;
                            u.rg    = 3'(b);
                            u.off   = 16'(n);
                            q.push_back(u);
                            n++;
                        end
                    end
                    q[q.size()-1].last = 1'b1;
                    cur   = q.pop_front();
                    cur_v = 1'b1;
                end
            end else begin
                cur.ir    = ir;
                cur.multi = 1'b0;
                cur.first = 1'b0;
                cur.last  = 1'b0;
                cur.rg    = 3'd0;
                cur.off   = 16'd0;
                cur_v     = 1'b1;
            end
        end else begin
            cur_v = 1'b0;
        end
    endtask

    // Compare DUT against the model every cycle, mid-period.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("valid", bus.out_valid, cur_v);
                check("busy", bus.busy, q.size() != 0);
                check("ready", bus.in_ready, q.size() == 0 && !bus.stall_in && !bus.flush);
                if (cur_v) begin
                    check("ir", bus.out_ir, cur.ir);
                    check("multi", bus.out_multi, cur.multi);
                    check("first", bus.out_first, cur.first);
                    check("last", bus.out_last, cur.last);
                    check("offset", bus.out_offset, cur.off);
                    if (cur.multi) check("reg", bus.out_reg, cur.rg);
                end
            end
        end
    end

    // Drive one cycle of inputs; returns just after the edge that consumed them.
    task automatic step(input logic v, input logic [15:0] ir, input logic st, input logic fl);
        bus.in_valid = v;
        bus.in_ir    = ir;
        bus.stall_in = st;
        bus.flush    = fl;
        @(negedge clk);
        #1;
        model_step(v, ir, st, fl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  opc;
        logic [7:0]  mask;
        logic [15:0] rir;
        int          r;

        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_ir    = '0;
        bus.stall_in = 1'b0;
        bus.flush    = 1'b0;
        b2.in_valid  = 1'b0;
        b2.in_ir     = '0;
        b2.stall_in  = 1'b0;
        b2.flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_ir", bus.out_ir, 16'h0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ready", bus.in_ready, 1'b1);
        check("rst_offset", bus.out_offset, 16'h0);
        reset  = 1'b1;
        chk_en = 1'b1;

        // LM rA=R3 mask 0xA5, then an ADD accepted back-to-back.
        step(1'b1, 16'h66A5, 1'b0, 1'b0);
        check("a5_reg0", bus.out_reg, 3'd0);
        check("a5_first0", bus.out_first, 1'b1);
        check("a5_ir0", bus.out_ir, 16'h6601);
        check("a5_ready0", bus.in_ready, 1'b0);
        step(1'b1, ADD, 1'b0, 1'b0);
        check("a5_reg1", bus.out_reg, 3'd2);
        check("a5_off1", bus.out_offset, 16'd1);
        step(1'b1, ADD, 1'b0, 1'b0);
        check("a5_reg2", bus.out_reg, 3'd5);
        check("a5_ready2", bus.in_ready, 1'b0);
        step(1'b1, ADD, 1'b0, 1'b0);
        check("a5_reg3", bus.out_reg, 3'd7);
        check("a5_off3", bus.out_offset, 16'd3);
        check("a5_last3", bus.out_last, 1'b1);
        check("a5_ready3", bus.in_ready, 1'b1);
        step(1'b1, ADD, 1'b0, 1'b0);
        check("add_ir", bus.out_ir, ADD);
        check("add_multi", bus.out_multi, 1'b0);
        check("add_ready", bus.in_ready, 1'b1);

        // SM with empty mask, then SM with only R7.
        step(1'b1, 16'h7600, 1'b0, 1'b0);
        check("sm0_valid", bus.out_valid, 1'b0);
        check("sm0_ready", bus.in_ready, 1'b1);
        step(1'b1, 16'h7680, 1'b0, 1'b0);
        check("sm80_reg", bus.out_reg, 3'd7);
        check("sm80_first", bus.out_first, 1'b1);
        check("sm80_last", bus.out_last, 1'b1);

        // Full mask with a two-cycle stall after the third micro-op.
        step(1'b1, 16'h60FF, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        check("stall_reg", bus.out_reg, 3'd2);
        check("stall_off", bus.out_offset, 16'd2);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check("resume_reg", bus.out_reg, 3'd3);
        check("resume_off", bus.out_offset, 16'd3);
        repeat (4) step(1'b0, 16'h0, 1'b0, 1'b0);
        check("full_last_off", bus.out_offset, 16'd7);

        // Flush while the second micro-op of mask 0x0F is on the output.
        step(1'b1, 16'h600F, 1'b0, 1'b0);
        step(1'b1, ADD, 1'b0, 1'b0);
        step(1'b1, ADD, 1'b0, 1'b1);
        check("flush_valid", bus.out_valid, 1'b0);
        check("flush_busy", bus.busy, 1'b0);
        bus.flush = 1'b0;
        #1;
        check("flush_ready", bus.in_ready, 1'b1);

        // Asynchronous reset in the middle of mask 0x3C.
        step(1'b1, 16'h603C, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        check("arst_valid", bus.out_valid, 1'b0);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_reg", bus.out_reg, 3'd0);
        check("arst_offset", bus.out_offset, 16'h0);
        q.delete();
        cur_v = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        step(1'b1, ADD, 1'b0, 1'b0);
        check("post_rst_add", bus.out_ir, ADD);

        // Wide configuration: 12 registers, step 2, mask 0x801.
        b2.in_valid = 1'b1;
        b2.in_ir    = 24'h600801;
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check("w_reg0", b2.out_reg, 4'd0);
        check("w_off0", b2.out_offset, 24'd0);
        check("w_ir0", b2.out_ir, 24'h600001);
        check("w_first0", b2.out_first, 1'b1);
        b2.in_valid = 1'b0;
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check("w_reg1", b2.out_reg, 4'd11);
        check("w_off1", b2.out_offset, 24'd2);
        check("w_ir1", b2.out_ir, 24'h600800);
        check("w_last1", b2.out_last, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check("w_idle", b2.out_valid, 1'b0);
        check("w_busy", b2.busy, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) begin
                opc = 4'b0110;
            end else if (r < 7) begin
                opc = 4'b0111;
            end else begin
                opc = 4'($urandom_range(0, 13));
                if (opc >= 4'd6) opc = opc + 4'd2;
            end
            r = int'($urandom_range(0, 9));
            if (r == 0) mask = 8'h00;
            else if (r == 1) mask = 8'hFF;
            else mask = 8'($urandom);
            rir = {opc, 4'($urandom), mask};
            step($urandom_range(0, 9) < 8, rir, $urandom_range(0, 99) < 12,
                 $urandom_range(0, 99) < 4);
        end
        step(1'b0, 16'h0, 1'b0, 1'b1);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_transfer_sequencer.md
Name: multi_transfer_sequencer

Overview:
- Decode-stage sequencer that expands block load/store instructions (LM/SM) into one single-register micro-op per set bit of the register mask.
- Sits between the IF/ID pipeline register and the ID/RR pipeline register.
- While expanding, stalls fetch through in_ready, which drives PC write and IR write.
- Replaces the fixed 8-register handling (first_multiple, modify_ir) with a parametrised block that supports stall, flush and empty-mask cases.

Parameters:
- WIDTH, 16: instruction and datapath width.
- NUM_REGS, 8: register count; mask field is in_ir[NUM_REGS-1:0]; must satisfy NUM_REGS <= WIDTH-7.
- RIDX, 3: register index width, equal to clog2(NUM_REGS).
- OPC_LM, 4'b0110: load-multiple opcode, compared against in_ir[WIDTH-1:WIDTH-4].
- OPC_SM, 4'b0111: store-multiple opcode.
- ADDR_STEP, 1: address offset increment per micro-op.

Ports:
- clk in 1: clock, rising edge.
- reset in 1: asynchronous, active-low reset.
- in_valid in 1: IF/ID holds a valid instruction.
- in_ir in WIDTH: instruction from IF/ID.
- in_ready out 1: sequencer can accept an instruction; drives PC write and IR write.
- stall_in in 1: downstream hold request.
- flush in 1: kill in-flight expansion (branch/jump resolved).
- out_valid out 1: micro-op valid to ID/RR.
- out_ir out WIDTH: micro-op instruction.
- out_multi out 1: micro-op came from LM/SM.
- out_first out 1: first micro-op of an expansion.
- out_last out 1: last micro-op of an expansion.
- out_reg out RIDX: register index of this micro-op.
- out_offset out WIDTH: address offset added to base register rA.
- busy out 1: pending mask is non-zero.

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, out_ir=0, out_multi=0, out_first=0, out_last=0, out_reg=0, out_offset=0, pending mask=0, busy=0. in_ready is combinational and therefore 1 after reset if stall_in=0 and flush=0.
- in_ready = (pending==0) && !stall_in && !flush.
- Accept occurs on a rising edge with in_valid && in_ready.
- States: IDLE (pending==0) and EXPAND (pending!=0). State is implied by the pending mask.
- Accept of a non-LM/SM instruction, latency 1:
  - out_ir=in_ir, out_valid=1, out_multi=0, out_first=0, out_last=0, out_offset=0.
- Accept of LM/SM with mask m!=0:
  - Loads the first micro-op from the lowest set bit b0: out_reg=b0, out_offset=0, out_first=1, out_multi=1.
  - out_ir = {in_ir[WIDTH-1:NUM_REGS], one-hot(b0)}.
  - pending <= m with b0 cleared; out_last = (pending_next==0).
  - The base instruction bits are held in a shadow register for the remaining micro-ops.
- Each edge in EXPAND with !stall_in && !flush:
  - Emit the lowest pending bit, clear it, increment offset by ADDR_STEP (mod 2^WIDTH).
  - out_first=0; out_last=1 on the final micro-op.
  - Emission is strictly in ascending register order.
- k set bits produce k consecutive micro-ops with no bubbles. in_ready is low for k-1 cycles after accept.
- A new instruction is accepted on the edge after the last micro-op is loaded, back-to-back with no bubble.
- LM/SM with mask==0: consumed, out_valid=0 that cycle, no stall.
- No accept, not EXPAND, !stall_in: out_valid <= 0 (bubble).
- stall_in=1 and no flush: all registers hold, including pending and offset.
- flush=1, synchronous: pending<=0, out_valid<=0, out_first/out_last/out_multi<=0.
  - flush takes priority over stall_in and over accept; an instruction presented the same cycle is not accepted.
- Reset mid-expansion: expansion is abandoned with no further micro-ops.
- Full mask (all NUM_REGS bits): NUM_REGS micro-ops, last offset = (NUM_REGS-1)*ADDR_STEP.

Decomposition:
- Shared package risc_pkg holds:
  - opcode constants OPC_LM, OPC_SM;
  - WIDTH and NUM_REGS defaults;
  - field positions for the opcode, rA [11:9] and the mask.
- Natural sub-module: lowest_set_bit_enc, parametrised NUM_REGS, pure combinational. Outputs are the index, the one-hot value, the mask with that bit cleared, and a remaining-is-zero flag.

Test Plan:
- LM, rA=R3, mask 0xA5, no stall -> 4 micro-ops over 4 cycles:
  - out_reg 0,2,5,7; out_offset 0,1,2,3;
  - out_first on the 1st, out_last on the 4th;
  - in_ready low for 3 cycles, then a back-to-back accept.
- ADD passthrough -> out_ir=in_ir one cycle later, out_multi=0, in_ready stays 1.
- SM mask 0x00 -> no out_valid, in_ready stays 1; SM mask 0x80 -> single micro-op with reg 7, out_first=out_last=1.
- LM mask 0xFF with stall_in high for 2 cycles after the 3rd micro-op -> outputs and offset hold at reg 2 / offset 2, then resume at reg 3 / offset 3.
- flush asserted on the 2nd micro-op of mask 0x0F -> out_valid=0 next cycle, busy=0, in_ready=1.
- reset low mid-expansion of mask 0x3C -> all outputs 0 immediately (asynchronous); after release a new ADD is accepted normally.
- NUM_REGS=12, WIDTH=24, ADDR_STEP=2, mask 0x801 -> out_reg 0 then 11, out_offset 0 then 2.
